// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request, IF/ID register, one-entry skid buffer.
// Optional stall counter port when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        hlt_fetched
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] pc_plus2;
  logic        ifid_valid_next;
  logic [15:0] ifid_instr_next, ifid_pc_plus2_next;
  logic        hlt_next;
  logic [15:0] buf_instr, buf_instr_next;
  logic [15:0] buf_pc_plus2, buf_pc_plus2_next;
  logic        rdata_is_hlt, buf_is_hlt;

  // Handshake: a request is live while imem_req=1; imem_valid closes it, redirect abandons it.
  assign imem_req     = (state == FETCH) && rst_n;
  assign imem_addr    = pc;
  assign pc_plus2     = pc + 16'd2;
  assign rdata_is_hlt = (imem_rdata[15:12] == 4'hF);
  assign buf_is_hlt   = (buf_instr[15:12] == 4'hF);

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    ifid_valid_next    = ifid_valid;
    ifid_instr_next    = ifid_instr;
    ifid_pc_plus2_next = ifid_pc_plus2;
    hlt_next           = hlt_fetched;
    buf_instr_next     = buf_instr;
    buf_pc_plus2_next  = buf_pc_plus2;
    if (redirect) begin
      // Any response arriving now belongs to the old address and is dropped.
      pc_next           = redirect_pc;
      ifid_valid_next   = 1'b0;
      hlt_next          = 1'b0;
      buf_instr_next    = 16'h0000;
      buf_pc_plus2_next = 16'h0000;
      state_next        = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            pc_next = pc_plus2;
            if (rdata_is_hlt) hlt_next = 1'b1;
            if (stall) begin
              buf_instr_next    = imem_rdata;
              buf_pc_plus2_next = pc_plus2;
              state_next        = HOLD;
            end else begin
              ifid_valid_next    = 1'b1;
              ifid_instr_next    = imem_rdata;
              ifid_pc_plus2_next = pc_plus2;
              state_next         = rdata_is_hlt ? HALT : FETCH;
            end
          end else if (!stall) begin
            ifid_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid_next    = 1'b1;
            ifid_instr_next    = buf_instr;
            ifid_pc_plus2_next = buf_pc_plus2;
            state_next         = buf_is_hlt ? HALT : FETCH;
          end
        end
        HALT: begin
          if (!stall) ifid_valid_next = 1'b0;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= 16'h0000;
      ifid_pc_plus2 <= 16'h0000;
      hlt_fetched   <= 1'b0;
      buf_instr     <= 16'h0000;
      buf_pc_plus2  <= 16'h0000;
    end else begin
      pc            <= pc_next;
      ifid_valid    <= ifid_valid_next;
      ifid_instr    <= ifid_instr_next;
      ifid_pc_plus2 <= ifid_pc_plus2_next;
      hlt_fetched   <= hlt_next;
      buf_instr     <= buf_instr_next;
      buf_pc_plus2  <= buf_pc_plus2_next;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Counts cycles where a live IF/ID instruction is blocked; saturates, ignores redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= 16'h0000;
    end else if (stall && ifid_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, random run against a queue-based model, RESET_PC wrap check.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, rdy;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_valid;
  logic [15:0] imem_addr, imem_rdata;
  logic        ifid_valid, hlt_fetched;
  logic [15:0] ifid_instr, ifid_pc_plus2;
  logic [15:0] mem [0:65535];

  logic        rst2_n;
  logic        req2, v2, hlt2;
  logic [15:0] addr2, instr2, pc22;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles, stall_cycles2;
`endif

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  // Memory: answers in the request cycle whenever rdy is high.
  assign imem_valid = imem_req & rdy;
  assign imem_rdata = mem[imem_addr];

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2), .hlt_fetched(hlt_fetched)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(16'h0123), .imem_valid(req2), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(16'h0000), .ifid_valid(v2),
    .ifid_instr(instr2), .ifid_pc_plus2(pc22), .hlt_fetched(hlt2)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  // Reference model: PC, IF/ID contents, halted flag and a queue of parked {pc+2, word}.
  logic [15:0] m_pc, m_instr, m_pc2, m_cnt;
  logic        m_v, m_hlt;
  logic [31:0] exp_q[$];

  function automatic logic model_req();
    return rst_n && !m_hlt && (exp_q.size() == 0);
  endfunction

  task automatic model_step();
    logic [15:0] w;
    logic [31:0] e;
    if (!rst_n) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000; m_cnt = 16'h0000;
      m_v = 1'b0; m_hlt = 1'b0; exp_q.delete();
    end else begin
      if (stall && m_v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (redirect) begin
        m_pc = redirect_pc; m_v = 1'b0; m_hlt = 1'b0; exp_q.delete();
      end else if (exp_q.size() != 0) begin
        if (!stall) begin
          e = exp_q.pop_front();
          m_v = 1'b1; m_pc2 = e[31:16]; m_instr = e[15:0];
        end
      end else if (m_hlt) begin
        if (!stall) m_v = 1'b0;
      end else if (rdy) begin
        w = mem[m_pc];
        if (stall) exp_q.push_back({16'(m_pc + 16'd2), w});
        else begin m_v = 1'b1; m_instr = w; m_pc2 = 16'(m_pc + 16'd2); end
        m_pc = 16'(m_pc + 16'd2);
        if (w[15:12] == 4'hF) m_hlt = 1'b1;
      end else if (!stall) begin
        m_v = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic d, input logic [15:0] rp, input logic y);
    rst_n = r; stall = s; redirect = d; redirect_pc = rp; rdy = y;
    #1;
  endtask

  task automatic check_model();
    check("m_req", {15'd0, imem_req}, {15'd0, model_req()});
    check("m_addr", imem_addr, m_pc);
    check("m_valid", {15'd0, ifid_valid}, {15'd0, m_v});
    if (m_v) begin
      check("m_instr", ifid_instr, m_instr);
      check("m_pc2", ifid_pc_plus2, m_pc2);
    end
    check("m_hlt", {15'd0, hlt_fetched}, {15'd0, m_hlt});
`ifdef FETCH_STALL_CNT_EN
    check("m_cnt", stall_cycles, m_cnt);
`endif
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst, stl, rd;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_instr, e_pc2;
    logic        e_hlt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0002, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h5678, 16'h0004, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b1, 16'h5678, 16'h0004, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0006, 1'b1, 16'h5678, 16'h0004, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0006, 1'b1, 16'h5678, 16'h0004, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 16'hABCD, 16'h0006, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 1'b0, 16'hABCD, 16'h0006, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b1, 16'hF000, 16'h0008, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0008, 1'b0, 16'hF000, 16'h0008, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0008, 1'b0, 16'hF000, 16'h0008, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0, 16'hF000, 16'h0008, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0012, 1'b1, 16'h1010, 16'h0012, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h1010, 16'h0012, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 1'b1, 16'h4444, 16'h0042, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0044, 1'b1, 16'h0000, 16'h0044, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0046, 1'b1, 16'h0000, 16'h0044, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1234; mem[16'h0002] = 16'h5678;
    mem[16'h0004] = 16'hABCD; mem[16'h0006] = 16'hF000;
    mem[16'h0010] = 16'h1010; mem[16'h0012] = 16'h1212;
    mem[16'h0040] = 16'h4444;

    // Clock/reset: two reset cycles for both instances.
    rst2_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      advance();
    end

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      check($sformatf("t%0d_req", i), {15'd0, imem_req}, {15'd0, tbl[i].e_req});
      check($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("t%0d_valid", i), {15'd0, ifid_valid}, {15'd0, tbl[i].e_v});
      check($sformatf("t%0d_instr", i), ifid_instr, tbl[i].e_instr);
      check($sformatf("t%0d_pc2", i), ifid_pc_plus2, tbl[i].e_pc2);
      check($sformatf("t%0d_hlt", i), {15'd0, hlt_fetched}, {15'd0, tbl[i].e_hlt});
`ifdef FETCH_STALL_CNT_EN
      check($sformatf("t%0d_cnt", i), stall_cycles, m_cnt);
`endif
      advance();
    end

    // Stall counter: five stalled cycles on a live IF/ID entry.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_model();
`ifdef FETCH_STALL_CNT_EN
    check("cnt_five", stall_cycles, 16'd5);
`endif
    advance();

    // Random run against the model.
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFA : (16'($urandom) & 16'hFFFE);
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0), rp, ($urandom_range(0, 3) != 0));
      check_model();
      advance();
    end

    // RESET_PC = FFFE: PC wraps to 0000 after the first fetch.
    rst2_n = 1'b1;
    #1;
    check("wrap_req", {15'd0, req2}, 16'd1);
    check("wrap_addr0", addr2, 16'hFFFE);
    @(posedge clk); @(negedge clk); #1;
    check("wrap_addr1", addr2, 16'h0000);
    check("wrap_valid", {15'd0, v2}, 16'd1);
    check("wrap_instr", instr2, 16'h0123);
    check("wrap_pc2", pc22, 16'h0000);
    @(posedge clk); @(negedge clk); #1;
    check("wrap_pc2b", pc22, 16'h0002);
    check("wrap_addr2", addr2, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  16  byte address of request (current PC).
REQ-006 SHALL have port imem_rdata  input  16  instruction word returned.
REQ-007 SHALL have port imem_valid  input  1  imem_rdata valid; same cycle as request or later.
REQ-008 SHALL have port stall  input  1  decode/hazard unit cannot accept new IF/ID contents.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  16  new fetch address when redirect=1.
REQ-011 SHALL have port ifid_valid  output  1  IF/ID register holds a live instruction.
REQ-012 SHALL have port ifid_instr  output  16  IF/ID instruction.
REQ-013 SHALL have port ifid_pc_plus2  output  16  address of that instruction plus 2.
REQ-014 SHALL have port hlt_fetched  output  1  HLT (opcode 4'hF) fetched; fetching stopped.
REQ-015 SHALL have port stall_cycles  output  16  stall counter; present only under FETCH_STALL_CNT_EN.

Function
REQ-016 SHALL implement states FETCH, HOLD, HALT; imem_req=1 only in FETCH with rst_n=1; imem_addr=pc at all times.
REQ-017 SHALL keep imem_addr stable until imem_valid or redirect; one outstanding request max.
REQ-018 FETCH, imem_valid=1, stall=0, redirect=0: next edge ifid_instr<=imem_rdata, ifid_pc_plus2<=pc+2, ifid_valid<=1, pc<=pc+2; zero-wait memory yields one instruction per cycle.
REQ-019 FETCH, imem_valid=0, stall=0: ifid_valid<=0 (bubble); pc unchanged.
REQ-020 stall=1: IF/ID register (valid, instr, pc_plus2) SHALL hold.
REQ-021 FETCH, imem_valid=1, stall=1: response captured in one-entry buffer, pc<=pc+2, state->HOLD (imem_req drops next cycle).
REQ-022 HOLD, stall=0: buffer moved into IF/ID at next edge, state->FETCH (or HALT if buffered word is HLT).
REQ-023 Captured word with imem_rdata[15:12]=4'hF SHALL set hlt_fetched<=1 and state->HALT; HALT issues no requests; pc stays at HLT address+2.
REQ-024 HALT, stall=0: ifid_valid<=0 after HLT consumed; HALT exited only by redirect or reset.
REQ-025 redirect=1 SHALL take priority over stall, imem_valid and every state: pc<=redirect_pc, ifid_valid<=0, buffer dropped, hlt_fetched<=0, state->FETCH.
REQ-026 imem_valid in a redirect cycle belongs to the old address and SHALL be discarded; memory SHALL abandon it; new request starts next cycle.
REQ-027 pc+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000).

Reset
REQ-028 rst_n=0 at an edge: pc<=RESET_PC, state<=FETCH, ifid_valid<=0, ifid_instr<=0, ifid_pc_plus2<=0, hlt_fetched<=0, buffer cleared, stall_cycles<=0.
REQ-029 imem_req SHALL be 0 while rst_n=0; reset mid-request or mid-HOLD discards all pending data; first request in the first cycle with rst_n=1.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: stall_cycles present, +1 each cycle with stall=1 and ifid_valid=1, saturating at 16'hFFFF, unaffected by redirect.
REQ-031 FETCH_STALL_CNT_EN undefined: stall_cycles port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset 2 cycles, zero-wait memory returning 16'h1234 @0000, 16'h5678 @0002 -> imem_addr 0000 then 0002; ifid_instr=1234/ifid_pc_plus2=0002, then 5678/0004 on consecutive cycles.
REQ-033 stall=1 for 3 cycles while valid response 16'hABCD arrives -> imem_req 0 in HOLD, IF/ID held; ABCD in ifid_instr one cycle after stall drops.
REQ-034 redirect=1 with redirect_pc=16'h0040 and stall=1 simultaneously -> next cycle ifid_valid=0, imem_addr=0040; response in redirect cycle dropped.
REQ-035 Fetch 16'hF000 at 0006 -> hlt_fetched=1, imem_req=0 thereafter, imem_addr=0008; later redirect to 0010 -> hlt_fetched=0, fetch resumes at 0010.
REQ-036 RESET_PC=16'hFFFE -> first fetch FFFE, second fetch 0000, ifid_pc_plus2=0000.
REQ-037 FETCH_STALL_CNT_EN defined, stall held 5 cycles with ifid_valid=1 -> stall_cycles=5; undefined build compiles without the port.
